// File: rtl/fibonacci_seq_gen.sv
// Additive-sequence generator: t[n]=t[n-1]+t[n-2] from two loaded seeds, streamed
// over a valid/ready port with wrap or saturate overflow handling.
module fibonacci_seq_gen #(
  parameter int WIDTH    = 16,
  parameter int IDX_W    = 8,
  parameter bit SAT_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [IDX_W-1:0] count,
  input  logic             s_ready,
  output logic             s_valid,
  output logic [WIDTH-1:0] s,
  output logic [IDX_W-1:0] s_idx,
  output logic             s_last,
  output logic             s_ovf,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] b;
  logic             b_ovf;
  logic [IDX_W-1:0] cnt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] b_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [IDX_W-1:0] cnt_m1;

  // s doubles as the older term register; b holds the next term to be emitted.
  assign sum     = {1'b0, s} + {1'b0, b};
  assign b_nxt   = (SAT_MODE && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  assign idx_nxt = s_idx + IDX_W'(1);
  assign cnt_m1  = cnt - IDX_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      s       <= '0;
      b       <= '0;
      b_ovf   <= 1'b0;
      cnt     <= '0;
      s_idx   <= '0;
      s_valid <= 1'b0;
      s_last  <= 1'b0;
      s_ovf   <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ovf    <= 1'b0;
            s_ovf  <= 1'b0;
            b_ovf  <= 1'b0;
            s_idx  <= '0;
            s_last <= 1'b0;
            busy   <= 1'b1;
            if (count != '0) begin
              s       <= seed0;
              b       <= seed1;
              cnt     <= count;
              s_last  <= (count == IDX_W'(1));
              s_valid <= 1'b1;
              state   <= RUN;
            end else begin
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        RUN: begin
          if (s_ready) begin
            ovf <= ovf | s_ovf;
            if (s_last) begin
              s_valid <= 1'b0;
              s_last  <= 1'b0;
              done    <= 1'b1;
              state   <= FIN;
            end else begin
              s      <= b;
              s_ovf  <= b_ovf;
              b      <= b_nxt;
              // Overflow taints every later term, not just the one that carried.
              b_ovf  <= sum[WIDTH] | s_ovf | b_ovf;
              s_idx  <= idx_nxt;
              s_last <= (idx_nxt == cnt_m1);
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
